// File: rtl/stage_seq_pkg.sv
// Shared types and constants for the processor stage sequencer.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package stage_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        HALT  = 2'd3
    } seq_state_t;

    // Default stage order of the classic five-step instruction cycle
    localparam int STG_PC  = 0;
    localparam int STG_MEM = 1;
    localparam int STG_DEC = 2;
    localparam int STG_REG = 3;
    localparam int STG_ALU = 4;

    // Index width for n items, never narrower than one bit
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_dwell_counter.sv
// Per-stage dwell up-counter; raises tc on its final count and saturates there.
// Latency: count updates one cycle after clr/hold; tc is combinational from the count.
// Backpressure: hold freezes the count; clr dominates hold.
module seq_dwell_counter
    import stage_seq_pkg::*;
#(
    parameter int MAX = 1
) (
    input  logic clk,
    input  logic arst_n,
    input  logic clr,
    input  logic hold,
    output logic tc
);

    localparam int W = idx_w(MAX);

    logic [W-1:0] count;

    assign tc = (count == W'(MAX - 1));

    // Count up to the terminal value and stay there until cleared
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (!hold && !tc) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/stage_sequencer.sv
// One-hot stage-enable sequencer with dwell, memory wait, stall, flush, single-step and halt.
// Latency: N_STAGES*STAGE_CYCLES cycles per instruction, all outputs registered.
// Backpressure: I_mem_ready low (at MEM_IDX final dwell) or I_stall high each add one cycle.
module stage_sequencer
    import stage_seq_pkg::*;
#(
    parameter int N_STAGES     = 5,
    parameter int MEM_IDX      = STG_MEM,
    parameter int STAGE_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic                         clk,
    input  logic                         I_reset,
    input  logic                         I_start,
    input  logic                         I_mem_ready,
    input  logic                         I_stall,
    input  logic                         I_flush,
    input  logic                         I_step_mode,
    input  logic                         I_step,
    input  logic                         I_halt,
    output logic [N_STAGES-1:0]          O_en,
    output logic [idx_w(N_STAGES)-1:0]   O_stage,
    output logic                         O_mem_req,
    output logic                         O_instr_done,
    output logic [CNT_W-1:0]             O_retired,
    output logic                         O_busy,
    output logic                         O_halted
);

    localparam int                SW       = idx_w(N_STAGES);
    localparam logic [SW-1:0]     MEM_STG  = SW'(MEM_IDX);
    localparam logic [SW-1:0]     LAST_STG = SW'(N_STAGES - 1);
    localparam logic [N_STAGES-1:0] EN_ONE = {{(N_STAGES-1){1'b0}}, 1'b1};

    seq_state_t    state;
    seq_state_t    state_nxt;
    logic [SW-1:0] stage_nxt;
    logic          halt_q;
    logic          halt_pend;
    logic          dwell_tc;
    logic          dwell_clr;
    logic          advance_ok;
    logic          boundary;

    // Stage register doubles as the O_stage output
    seq_dwell_counter #(
        .MAX (STAGE_CYCLES)
    ) u_dwell (
        .clk    (clk),
        .arst_n (I_reset),
        .clr    (dwell_clr),
        .hold   (I_stall),
        .tc     (dwell_tc)
    );

    // Dwell done and, on the memory stage, memory has answered
    assign advance_ok = dwell_tc && !((O_stage == MEM_STG) && !I_mem_ready);
    // A halt raised on the boundary cycle itself is honoured immediately
    assign halt_pend  = halt_q || I_halt;
    // Dwell restarts on every new stage and stays at zero outside RUN
    assign dwell_clr  = (state != RUN) || I_flush || (!I_stall && advance_ok);

    // Next state / next stage decode: flush beats stall beats advance
    always_comb begin
        state_nxt = state;
        stage_nxt = O_stage;
        boundary  = 1'b0;
        case (state)
            IDLE: begin
                if (I_start) begin
                    state_nxt = RUN;
                    stage_nxt = '0;
                end
            end
            RUN: begin
                if (I_flush) begin
                    stage_nxt = '0;
                end else if (I_stall) begin
                    stage_nxt = O_stage;
                end else if (advance_ok) begin
                    if (O_stage == LAST_STG) begin
                        boundary  = 1'b1;
                        stage_nxt = '0;
                        if (halt_pend) begin
                            state_nxt = HALT;
                        end else if (I_step_mode) begin
                            state_nxt = PAUSE;
                        end
                    end else begin
                        stage_nxt = O_stage + SW'(1);
                    end
                end
            end
            PAUSE: begin
                if (halt_pend) begin
                    state_nxt = HALT;
                end else if (I_step) begin
                    state_nxt = RUN;
                    stage_nxt = '0;
                end
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = IDLE;
                stage_nxt = '0;
            end
        endcase
    end

    // FSM state, sticky halt latch and registered outputs derived from the next state
    always_ff @(posedge clk or negedge I_reset) begin
        if (!I_reset) begin
            state        <= IDLE;
            halt_q       <= 1'b0;
            O_stage      <= '0;
            O_en         <= '0;
            O_mem_req    <= 1'b0;
            O_instr_done <= 1'b0;
            O_retired    <= '0;
            O_busy       <= 1'b0;
            O_halted     <= 1'b0;
        end else begin
            state        <= state_nxt;
            O_stage      <= stage_nxt;
            if ((state != IDLE) && I_halt) begin
                halt_q <= 1'b1;
            end
            O_en         <= (state_nxt == RUN) ? (EN_ONE << stage_nxt) : '0;
            O_mem_req    <= (state_nxt == RUN) && (stage_nxt == MEM_STG);
            O_instr_done <= boundary;
            if (boundary) begin
                O_retired <= O_retired + CNT_W'(1);
            end
            O_busy       <= (state_nxt == RUN);
            O_halted     <= (state_nxt == HALT);
        end
    end

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: default-config vector table plus corner sequences,
// and a second instance with two-cycle dwell and a 2-bit retire counter.
// Inputs change 1ns after the rising edge; outputs are compared at that same point.
module tb_stage_sequencer;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    logic start, mem_ready, stall, flush, step_mode, step, halt;

    logic [4:0]  en_a, en_b;
    logic [2:0]  stage_a, stage_b;
    logic        mreq_a, mreq_b, done_a, done_b, busy_a, busy_b, hlt_a, hlt_b;
    logic [15:0] ret_a;
    logic [1:0]  ret_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [6:0]  in;   // {start, mem_ready, stall, flush, step_mode, step, halt}
        logic [4:0]  en;
        logic        done;
        logic [15:0] ret;
        logic        busy;
        logic        hlt;
    } vec_t;

    vec_t vt[$];

    always #5 clk = ~clk;

    stage_sequencer u_a (
        .clk(clk), .I_reset(rst_a), .I_start(start), .I_mem_ready(mem_ready),
        .I_stall(stall), .I_flush(flush), .I_step_mode(step_mode), .I_step(step),
        .I_halt(halt), .O_en(en_a), .O_stage(stage_a), .O_mem_req(mreq_a),
        .O_instr_done(done_a), .O_retired(ret_a), .O_busy(busy_a), .O_halted(hlt_a)
    );

    stage_sequencer #(.N_STAGES(5), .MEM_IDX(1), .STAGE_CYCLES(2), .CNT_W(2)) u_b (
        .clk(clk), .I_reset(rst_b), .I_start(start), .I_mem_ready(mem_ready),
        .I_stall(stall), .I_flush(flush), .I_step_mode(step_mode), .I_step(step),
        .I_halt(halt), .O_en(en_b), .O_stage(stage_b), .O_mem_req(mreq_b),
        .O_instr_done(done_b), .O_retired(ret_b), .O_busy(busy_b), .O_halted(hlt_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [6:0] in, input logic [4:0] en, input int done,
                                input int ret, input int busy, input int hlt);
        vec_t v;
        v.in   = in;
        v.en   = en;
        v.done = (done != 0);
        v.ret  = 16'(ret);
        v.busy = (busy != 0);
        v.hlt  = (hlt != 0);
        return v;
    endfunction

    function automatic logic [2:0] stage_of(input logic [4:0] en);
        logic [2:0] s;
        s = 3'd0;
        for (int i = 0; i < 5; i++) begin
            if (en[i]) s = 3'(i);
        end
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] in);
        {start, mem_ready, stall, flush, step_mode, step, halt} = in;
    endtask

    task automatic check_a(input string tag, input logic [4:0] en, input logic done,
                           input logic [15:0] ret, input logic busy, input logic hlt);
        check({tag, " en"},     32'(en_a),    32'(en));
        check({tag, " stage"},  32'(stage_a), 32'(stage_of(en)));
        check({tag, " memreq"}, 32'(mreq_a),  32'(en == 5'b00010));
        check({tag, " done"},   32'(done_a),  32'(done));
        check({tag, " retired"},32'(ret_a),   32'(ret));
        check({tag, " busy"},   32'(busy_a),  32'(busy));
        check({tag, " halted"}, 32'(hlt_a),   32'(hlt));
    endtask

    // Pulse reset on instance A between the edges
    task automatic reset_a();
        rst_a = 1'b0;
        drive(7'b0100000);
        #2;
        check_a("rst_a", 5'b00000, 1'b0, 16'd0, 1'b0, 1'b0);
        rst_a = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;
        drive(7'b0100000);
        #3;
        check_a("reset", 5'b00000, 1'b0, 16'd0, 1'b0, 1'b0);
        check("reset b en",      32'(en_b),   32'd0);
        check("reset b retired", 32'(ret_b),  32'd0);
        check("reset b halted",  32'(hlt_b),  32'd0);
        tick();
        check_a("reset held", 5'b00000, 1'b0, 16'd0, 1'b0, 1'b0);
        rst_a = 1'b1;
        tick();
        check_a("idle", 5'b00000, 1'b0, 16'd0, 1'b0, 1'b0);

        // Continuous run, retire count rising every five cycles
        vt.push_back(mk(7'b1100000, 5'b00001, 0, 0, 1, 0));
        vt.push_back(mk(7'b0100000, 5'b00010, 0, 0, 1, 0));
        vt.push_back(mk(7'b0100000, 5'b00100, 0, 0, 1, 0));
        vt.push_back(mk(7'b0100000, 5'b01000, 0, 0, 1, 0));
        vt.push_back(mk(7'b0100000, 5'b10000, 0, 0, 1, 0));
        vt.push_back(mk(7'b0100000, 5'b00001, 1, 1, 1, 0));
        vt.push_back(mk(7'b0100000, 5'b00010, 0, 1, 1, 0));
        vt.push_back(mk(7'b0100000, 5'b00100, 0, 1, 1, 0));
        vt.push_back(mk(7'b0100000, 5'b01000, 0, 1, 1, 0));
        vt.push_back(mk(7'b0100000, 5'b10000, 0, 1, 1, 0));
        vt.push_back(mk(7'b0100000, 5'b00001, 1, 2, 1, 0));
        // Memory wait: three not-ready cycles hold stage 1 for four cycles
        vt.push_back(mk(7'b0100000, 5'b00010, 0, 2, 1, 0));
        vt.push_back(mk(7'b0000000, 5'b00010, 0, 2, 1, 0));
        vt.push_back(mk(7'b0000000, 5'b00010, 0, 2, 1, 0));
        vt.push_back(mk(7'b0000000, 5'b00010, 0, 2, 1, 0));
        vt.push_back(mk(7'b0100000, 5'b00100, 0, 2, 1, 0));
        vt.push_back(mk(7'b0100000, 5'b01000, 0, 2, 1, 0));
        vt.push_back(mk(7'b0100000, 5'b10000, 0, 2, 1, 0));
        vt.push_back(mk(7'b0100000, 5'b00001, 1, 3, 1, 0));
        // Stall two cycles at stage 2, then flush at stage 3
        vt.push_back(mk(7'b0100000, 5'b00010, 0, 3, 1, 0));
        vt.push_back(mk(7'b0100000, 5'b00100, 0, 3, 1, 0));
        vt.push_back(mk(7'b0110000, 5'b00100, 0, 3, 1, 0));
        vt.push_back(mk(7'b0110000, 5'b00100, 0, 3, 1, 0));
        vt.push_back(mk(7'b0100000, 5'b01000, 0, 3, 1, 0));
        vt.push_back(mk(7'b0101000, 5'b00001, 0, 3, 1, 0));
        vt.push_back(mk(7'b0100000, 5'b00010, 0, 3, 1, 0));
        // Single-step: pause after the boundary, flush ignored, step resumes
        vt.push_back(mk(7'b0100100, 5'b00100, 0, 3, 1, 0));
        vt.push_back(mk(7'b0100100, 5'b01000, 0, 3, 1, 0));
        vt.push_back(mk(7'b0100100, 5'b10000, 0, 3, 1, 0));
        vt.push_back(mk(7'b0100100, 5'b00000, 1, 4, 0, 0));
        vt.push_back(mk(7'b0101100, 5'b00000, 0, 4, 0, 0));
        vt.push_back(mk(7'b0100110, 5'b00001, 0, 4, 1, 0));
        vt.push_back(mk(7'b0100000, 5'b00010, 0, 4, 1, 0));
        // Halt pulse at stage 1: instruction completes, then HALT ignores start/step/flush
        vt.push_back(mk(7'b0100001, 5'b00100, 0, 4, 1, 0));
        vt.push_back(mk(7'b0100000, 5'b01000, 0, 4, 1, 0));
        vt.push_back(mk(7'b0100000, 5'b10000, 0, 4, 1, 0));
        vt.push_back(mk(7'b0100000, 5'b00000, 1, 5, 0, 1));
        vt.push_back(mk(7'b1100010, 5'b00000, 0, 5, 0, 1));
        vt.push_back(mk(7'b0101000, 5'b00000, 0, 5, 0, 1));

        foreach (vt[i]) begin
            drive(vt[i].in);
            tick();
            check_a($sformatf("vec%0d", i), vt[i].en, vt[i].done, vt[i].ret, vt[i].busy, vt[i].hlt);
        end

        // Halt requested while paused goes straight to HALT; step afterwards ignored
        reset_a();
        drive(7'b1100100);
        tick();
        drive(7'b0100100);
        for (int i = 0; i < 4; i++) tick();
        check_a("pause run", 5'b10000, 1'b0, 16'd0, 1'b1, 1'b0);
        tick();
        check_a("pause in", 5'b00000, 1'b1, 16'd1, 1'b0, 1'b0);
        drive(7'b0100101);
        tick();
        check_a("pause halt", 5'b00000, 1'b0, 16'd1, 1'b0, 1'b1);
        drive(7'b0100110);
        tick();
        check_a("halt step", 5'b00000, 1'b0, 16'd1, 1'b0, 1'b1);

        // Halt latch survives a flush and takes effect at the next boundary
        reset_a();
        drive(7'b1100000);
        tick();
        drive(7'b0100000);
        tick();
        drive(7'b0100001);
        tick();
        drive(7'b0101000);
        tick();
        check_a("flush keep", 5'b00001, 1'b0, 16'd0, 1'b1, 1'b0);
        drive(7'b0100000);
        for (int i = 0; i < 4; i++) tick();
        check_a("flush run", 5'b10000, 1'b0, 16'd0, 1'b1, 1'b0);
        tick();
        check_a("flush halt", 5'b00000, 1'b1, 16'd1, 1'b0, 1'b1);

        // Two-cycle dwell with a 2-bit retire counter that wraps
        rst_b = 1'b1;
        drive(7'b1100000);
        for (int k = 0; k < 47; k++) begin
            tick();
            drive(7'b0100000);
            check($sformatf("b en k%0d", k),      32'(en_b),   32'(1) << ((k % 10) / 2));
            check($sformatf("b done k%0d", k),    32'(done_b), 32'((k % 10 == 0) && (k > 0)));
            check($sformatf("b retired k%0d", k), 32'(ret_b),  32'((k / 10) % 4));
        end
        check("b busy mid", 32'(busy_b), 32'd1);
        #2;
        rst_b = 1'b0;
        #1;
        check("b async en",      32'(en_b),    32'd0);
        check("b async stage",   32'(stage_b), 32'd0);
        check("b async memreq",  32'(mreq_b),  32'd0);
        check("b async done",    32'(done_b),  32'd0);
        check("b async retired", 32'(ret_b),   32'd0);
        check("b async busy",    32'(busy_b),  32'd0);
        check("b async halted",  32'(hlt_b),   32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
